// File: rtl/nn_pkg.sv
// Shared widths, FSM state encodings and the lane readout function for the
// ten-lane neuron array.
package nn_pkg;

    localparam int N_LANES = 10;
    localparam int DATA_W  = 16;
    localparam int FRAC    = 8;
    localparam int ACC_W   = 42;
    localparam int CNT_W   = 10;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int SHIFT_W = ACC_W - FRAC;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_CNT = 2'd1;
    localparam logic [1:0] ST_MAC      = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic signed [SHIFT_W-1:0] SAT_MAX = SHIFT_W'(32767);
    localparam logic signed [SHIFT_W-1:0] SAT_MIN = SHIFT_W'(-32768);

    // Dropping the low FRAC bits is the arithmetic shift (rounds toward -inf).
    function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] acc,
                                                   input logic relu);
        logic signed [SHIFT_W-1:0] r;
        logic [DATA_W-1:0] out;
        r = acc[ACC_W-1:FRAC];
        if (r > SAT_MAX)
            out = 16'h7FFF;
        else if (r < SAT_MIN)
            out = 16'h8000;
        else
            out = r[DATA_W-1:0];
        if (relu && r[SHIFT_W-1])
            out = '0;
        return out;
    endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron lane: bias-seeded Q16.16 accumulator with a shift/saturate/ReLU
// readout back to Q8.8.
module nn_mac_lane
    import nn_pkg::*;
(
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     seed,
    input  logic                     bias_en,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     accumulate,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic                     relu_en,
    output logic [DATA_W-1:0]        result
);

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  bias_seed;

    assign prod      = x * w;
    assign bias_seed = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};

    always_ff @(posedge clock) begin
        if (rst)
            acc <= '0;
        else if (seed)
            acc <= bias_en ? bias_seed : '0;
        else if (accumulate)
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    assign result = sat_relu(acc, relu_en);

endmodule

// File: rtl/node_array.sv
// Ten-lane MAC array behind the layer controller: captures a beat count,
// runs the chunk, then serves one lane result per data_select.
//
// state    | meaning
// IDLE     | no chunk since reset
// WAIT_CNT | x data carries the beat count; seed accumulators
// MAC      | one multiply-accumulate per beat until count reaches 0
// DONE     | results valid, readout mux active
module node_array
    import nn_pkg::*;
(
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        head_c2node,
    input  logic [3:0]                  data_select_c2node,
    input  logic                        bias_en_c2node,
    input  logic                        relu_en_c2node,
    input  logic [DATA_W-1:0]           x_data_mem2node,
    input  logic [N_LANES*DATA_W-1:0]   w_data_mem2node,
    input  logic [N_LANES*DATA_W-1:0]   b_data_mem2node,
    output logic                        done_flag_node2c,
    output logic [DATA_W-1:0]           result_node2mem
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic              seed;
    logic              accumulate;
    logic [DATA_W-1:0] lane_result [N_LANES];

    assign seed       = (state == ST_WAIT_CNT);
    assign accumulate = (state == ST_MAC) && !head_c2node;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        nn_mac_lane u_lane (
            .clock      (clock),
            .rst        (rst),
            .seed       (seed),
            .bias_en    (bias_en_c2node),
            .bias       (b_data_mem2node[DATA_W*i +: DATA_W]),
            .accumulate (accumulate),
            .x          (x_data_mem2node),
            .w          (w_data_mem2node[DATA_W*i +: DATA_W]),
            .relu_en    (relu_en_c2node),
            .result     (lane_result[i])
        );
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state            <= ST_IDLE;
            count            <= '0;
            done_flag_node2c <= 1'b0;
            result_node2mem  <= '0;
        end else begin
            if (state == ST_DONE)
                result_node2mem <= (data_select_c2node < 4'(N_LANES))
                                   ? lane_result[data_select_c2node] : '0;

            // A head outside WAIT_CNT always restarts, including mid-MAC.
            if (head_c2node && state != ST_WAIT_CNT) begin
                state            <= ST_WAIT_CNT;
                done_flag_node2c <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_CNT: begin
                        count <= x_data_mem2node[CNT_W-1:0];
                        if (x_data_mem2node[CNT_W-1:0] == '0) begin
                            state            <= ST_DONE;
                            done_flag_node2c <= 1'b1;
                        end else begin
                            state <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state            <= ST_DONE;
                            done_flag_node2c <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_node_array.sv
// Directed bench for node_array: each chunk is driven beat by beat with
// hand-computed Q8.8 results checked at the readout.
module tb_node_array;
    import nn_pkg::*;

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic         head_c2node = 1'b0;
    logic [3:0]   data_select_c2node = '0;
    logic         bias_en_c2node = 1'b0;
    logic         relu_en_c2node = 1'b0;
    logic [15:0]  x_data_mem2node = '0;
    logic [159:0] w_data_mem2node = '0;
    logic [159:0] b_data_mem2node = '0;
    logic         done_flag_node2c;
    logic [15:0]  result_node2mem;

    int tests = 0;
    int failed = 0;

    node_array dut (
        .clock              (clock),
        .rst                (rst),
        .head_c2node        (head_c2node),
        .data_select_c2node (data_select_c2node),
        .bias_en_c2node     (bias_en_c2node),
        .relu_en_c2node     (relu_en_c2node),
        .x_data_mem2node    (x_data_mem2node),
        .w_data_mem2node    (w_data_mem2node),
        .b_data_mem2node    (b_data_mem2node),
        .done_flag_node2c   (done_flag_node2c),
        .result_node2mem    (result_node2mem)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] fill(input logic [15:0] v);
        return {10{v}};
    endfunction

    // Head edge, then the count edge with bias data presented.
    task automatic start(input int cnt, input logic bias, input logic [159:0] bpk);
        head_c2node = 1'b1;
        step();
        check("done_low_after_head", {15'd0, done_flag_node2c}, 16'd0);
        head_c2node     = 1'b0;
        x_data_mem2node = 16'(cnt);
        bias_en_c2node  = bias;
        b_data_mem2node = bpk;
        step();
    endtask

    // cnt MAC beats; done must rise exactly on the last one.
    task automatic beats(input int cnt, input logic [15:0] x, input logic [159:0] wpk);
        x_data_mem2node = x;
        w_data_mem2node = wpk;
        for (int i = 0; i < cnt; i++) begin
            check("done_low_during_mac", {15'd0, done_flag_node2c}, 16'd0);
            step();
        end
        check("done_high_after_chunk", {15'd0, done_flag_node2c}, 16'd1);
    endtask

    task automatic read(input string tag, input int sel, input logic relu, input logic [15:0] exp);
        data_select_c2node = 4'(sel);
        relu_en_c2node     = relu;
        step();
        check(tag, result_node2mem, exp);
    endtask

    initial begin
        logic [159:0] wpk;
        logic [159:0] bpk;

        step();
        step();
        check("reset_done", {15'd0, done_flag_node2c}, 16'd0);
        check("reset_result", result_node2mem, 16'h0000);
        rst = 1'b0;
        step();

        // 3 beats of 1.0*2.0 plus bias 0.5 -> 6.5
        start(3, 1'b1, fill(16'h0080));
        beats(3, 16'h0100, fill(16'h0200));
        for (int k = 0; k < 10; k++)
            read("bias_mac_lane", k, 1'b1, 16'h0680);

        start(4, 1'b0, fill(16'h0000));
        beats(4, 16'h7FFF, fill(16'h7FFF));
        read("pos_sat_lane0", 0, 1'b1, 16'h7FFF);
        read("pos_sat_lane9", 9, 1'b0, 16'h7FFF);

        start(4, 1'b0, fill(16'h0000));
        beats(4, 16'h7FFF, fill(16'h8000));
        read("neg_sat_lane2", 2, 1'b0, 16'h8000);
        read("neg_sat_lane7", 7, 1'b0, 16'h8000);
        read("neg_sat_relu", 5, 1'b1, 16'h0000);

        wpk = fill(16'h0100);
        wpk[63:48] = 16'hFF00;
        start(2, 1'b0, fill(16'h0000));
        beats(2, 16'h0100, wpk);
        read("neg_lane3_relu", 3, 1'b1, 16'h0000);
        read("neg_lane3_norelu", 3, 1'b0, 16'hFE00);
        read("pos_lane2", 2, 1'b1, 16'h0200);
        read("pos_lane4", 4, 1'b0, 16'h0200);

        // Count 0: bias passes straight through
        for (int i = 0; i < 10; i++)
            bpk[16*i +: 16] = 16'(i * 256);
        start(0, 1'b1, bpk);
        check("zero_count_done", {15'd0, done_flag_node2c}, 16'd1);
        for (int k = 0; k < 10; k++)
            read("zero_count_lane", k, 1'b0, 16'(k * 256));
        for (int k = 10; k < 16; k++)
            read("sel_out_of_range", k, 1'b0, 16'h0000);

        // Back-to-back restart from DONE
        read("pre_b2b_lane9", 9, 1'b0, 16'h0900);
        start(1, 1'b0, fill(16'h0000));
        check("b2b_done_low_e1", {15'd0, done_flag_node2c}, 16'd0);
        beats(1, 16'h0100, fill(16'h0100));
        read("b2b_lane9", 9, 1'b0, 16'h0100);
        read("b2b_lane1", 1, 1'b1, 16'h0100);

        // Reset during MAC
        start(5, 1'b1, fill(16'h1000));
        x_data_mem2node = 16'h0100;
        w_data_mem2node = fill(16'h0100);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_done", {15'd0, done_flag_node2c}, 16'd0);
        check("rst_mid_result", result_node2mem, 16'h0000);
        check("rst_mid_state", {14'd0, dut.state}, {14'd0, ST_IDLE});

        start(1, 1'b0, fill(16'h0000));
        data_select_c2node = 4'd2;
        check("hold_outside_done", result_node2mem, 16'h0000);
        beats(1, 16'h0100, fill(16'h0100));
        read("post_rst_lane6", 6, 1'b0, 16'h0100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/node_array.md
Name: node_array

Overview:
- Ten-lane neuron compute array sitting directly downstream of the layer controller.
- Consumes head_c2node, data_select_c2node and the memory read data for the x, w1..w10 and b1..b10 addresses the controller drives.
- Runs one chunk of multiply-accumulates, raises done_flag_node2c, then presents one lane result per data_select value for write-back to memory.

Parameters:
- N_LANES, 10, number of neuron lanes; fixed by the controller fan-out.
- DATA_W, 16, signed Q8.8 operand and result width.
- FRAC, 8, fractional bits.
- ACC_W, 42, signed accumulator width; holds 1023 full-scale products without overflow.
- CNT_W, 10, beat-count width.

Ports:
- clock  in  1  system clock.
- rst  in  1  reset.
- head_c2node  in  1  chunk start; memory x data on the next cycle is the beat count.
- data_select_c2node  in  4  lane select for result readout; 0..9 valid.
- bias_en_c2node  in  1  sampled at count capture; 1 seeds accumulators with bias.
- relu_en_c2node  in  1  1 applies ReLU on readout; 0 for layer 3 / softmax input.
- x_data_mem2node  in  16  x operand, or beat count in bits [9:0] after head.
- w_data_mem2node  in  160  packed w1..w10 data, lane i at bits [16i+15:16i].
- b_data_mem2node  in  160  packed b1..b10 data, same packing.
- done_flag_node2c  out  1  chunk complete, results valid.
- result_node2mem  out  16  selected lane result, Q8.8.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clock. Reset forces state IDLE and clears all accumulators, count, done_flag_node2c and result_node2mem. Reset mid-operation aborts the chunk with no partial result kept.
- Memory read latency is 1 cycle; data on the *_mem2node inputs at an edge belongs to the address driven in the previous cycle.
- States: IDLE, WAIT_CNT, MAC, DONE.
- Head in any state except WAIT_CNT: head_c2node=1 at edge E0 moves the block to WAIT_CNT and clears done_flag. Head during MAC aborts the chunk and restarts.
- WAIT_CNT, edge E1:
  - count <= x_data[9:0].
  - acc_i <= bias_en ? sext(b_i) << FRAC : 0.
  - Go to MAC if count != 0, otherwise go to DONE.
- MAC, edges E2..E(N+1): acc_i += sext(x) * sext(w_i), a 32-bit Q16.16 product sign-extended to ACC_W. Remaining count decrements each edge; after the edge where it reaches 0, go to DONE.
- done_flag_node2c is registered and equals (state==DONE), so it goes high after edge E(N+1).
- DONE:
  - Hold accumulators and keep done_flag=1 until the next head or reset.
  - result_node2mem is registered, updated every edge in DONE from the data_select value at that edge (1-cycle latency).
  - Per lane: r = acc_i >>> FRAC (arithmetic shift, truncation toward -inf). Saturate r to [-32768, 32767]. If relu_en and r < 0, r = 0.
  - data_select >= 10 gives result 0.
- Outside DONE, result_node2mem holds its last value.
- head_c2node sampled in WAIT_CNT is ignored.
- data_select changes outside DONE have no effect.
- Accumulators never wrap; ACC_W is sized for count <= 1023.

Decomposition:
- nn_pkg holds DATA_W, FRAC, ACC_W, CNT_W, N_LANES, the state enum and the saturate/relu function.
- Sub-module nn_mac_lane, instantiated N_LANES times, holds one accumulator, the seed/accumulate controls, and the shift/saturate/ReLU readout.
- node_array keeps the FSM, the count and the readout mux.

Test Plan:
- count=3, x=0x0100, all w=0x0200, all b=0x0080, bias_en=1, relu_en=1 -> done high 4 edges after head; each sel 0..9 reads 0x0680 one cycle after sel is applied.
- count=4, x=0x7FFF, w=0x7FFF, bias_en=0 -> all results 0x7FFF (positive saturation); with w=0x8000, relu_en=0 -> 0x8000.
- count=2, x=0x0100, lane 3 w=0xFF00 (-1.0), others 0x0100, bias_en=0 -> lane 3 reads 0x0000 with relu_en=1 and 0xFE00 with relu_en=0; other lanes read 0x0200.
- count=0, bias_en=1, b_i = i*0x0100 -> done 1 edge after head; sel=i reads i*0x0100; sel=10..15 reads 0x0000.
- Back-to-back: in DONE, assert head with new count=1, x=0x0100, w=0x0100, bias_en=0 -> done drops after the head edge and returns after 2 edges; results 0x0100 with no carry-over from the prior chunk.
- rst asserted mid-MAC (count=5, after 2 beats) -> next edge: done=0, result=0, state IDLE; a following head with count=1 produces a clean result.
